// File: rtl/zbs_unit_if.sv
// rtl/zbs_unit_if.sv - request/result handshake bundle for zbs_unit
// Optional mask_out signal present when ZBS_ONEHOT_OUT_EN is defined.
interface zbs_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [4:0]       tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [4:0]       out_tag;
`ifdef ZBS_ONEHOT_OUT_EN
    logic [WIDTH-1:0] mask_out;
`endif

    modport master (
        output in_valid, op, rs1, rs2, tag, flush, out_ready,
`ifdef ZBS_ONEHOT_OUT_EN
        input  mask_out,
`endif
        input  in_ready, out_valid, y, out_tag
    );

    modport slave (
        input  in_valid, op, rs1, rs2, tag, flush, out_ready,
`ifdef ZBS_ONEHOT_OUT_EN
        output mask_out,
`endif
        output in_ready, out_valid, y, out_tag
    );
endinterface

// File: rtl/zbs_unit.sv
// rtl/zbs_unit.sv - two-stage bset/bclr/binv/bext pipeline with valid/ready flow control
// ZBS_ONEHOT_OUT_EN adds an S2-registered one-hot mask output (mask_out).
module zbs_unit #(
    parameter int WIDTH   = 64,
    parameter int INDEX_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    zbs_unit_if.slave   bus
);

    localparam logic [1:0] OP_BSET = 2'b00;
    localparam logic [1:0] OP_BCLR = 2'b01;
    localparam logic [1:0] OP_BINV = 2'b10;
    localparam logic [1:0] OP_BEXT = 2'b11;

    function automatic logic [WIDTH-1:0] index_onehot(input logic [INDEX_W-1:0] idx);
        logic [WIDTH-1:0] dec;
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = (idx == INDEX_W'(i));
        end
        return dec;
    endfunction

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_rs1_q, s1_rs1_d;
    logic [4:0]       s1_tag_q, s1_tag_d;
    logic [WIDTH-1:0] s1_mask_q, s1_mask_d;

    // S2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic [4:0]       s2_tag_q, s2_tag_d;
`ifdef ZBS_ONEHOT_OUT_EN
    logic [WIDTH-1:0] s2_mask_q, s2_mask_d;
`endif

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] result;
    logic             unused_rs2_hi;

    // Upper index bits are architecturally ignored.
    assign unused_rs2_hi = ^bus.rs2[WIDTH-1:INDEX_W];

    // Ready depends only on stage occupancy and out_ready, never on in_valid.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;
    assign accept       = bus.in_valid && s1_adv;

    always_comb begin
        result = '0;
        unique case (s1_op_q)
            OP_BSET: result = s1_rs1_q | s1_mask_q;
            OP_BCLR: result = s1_rs1_q & ~s1_mask_q;
            OP_BINV: result = s1_rs1_q ^ s1_mask_q;
            OP_BEXT: result = {{(WIDTH-1){1'b0}}, |(s1_rs1_q & s1_mask_q)};
            default: result = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rs1_d   = s1_rs1_q;
        s1_tag_d   = s1_tag_q;
        s1_mask_d  = s1_mask_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_tag_d   = s2_tag_q;
`ifdef ZBS_ONEHOT_OUT_EN
        s2_mask_d  = s2_mask_q;
`endif
        if (bus.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_y_d    = result;
                    s2_tag_d  = s1_tag_q;
`ifdef ZBS_ONEHOT_OUT_EN
                    s2_mask_d = s1_mask_q;
`endif
                end
            end
            if (s1_adv) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_op_d   = bus.op;
                    s1_rs1_d  = bus.rs1;
                    s1_tag_d  = bus.tag;
                    s1_mask_d = index_onehot(bus.rs2[INDEX_W-1:0]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_tag_q   <= '0;
`ifdef ZBS_ONEHOT_OUT_EN
            s2_mask_q  <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_tag_q   <= s2_tag_d;
`ifdef ZBS_ONEHOT_OUT_EN
            s2_mask_q  <= s2_mask_d;
`endif
        end
    end

    // S1 datapath carries no reset; only its valid bit matters.
    always_ff @(posedge clk) begin
        s1_op_q   <= s1_op_d;
        s1_rs1_q  <= s1_rs1_d;
        s1_tag_q  <= s1_tag_d;
        s1_mask_q <= s1_mask_d;
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.y         = s2_y_q;
    assign bus.out_tag   = s2_tag_q;
`ifdef ZBS_ONEHOT_OUT_EN
    assign bus.mask_out  = s2_mask_q;
`endif

endmodule

// File: tb/tb_zbs_unit.sv
// tb/tb_zbs_unit.sv - directed self-checking bench for zbs_unit
module tb_zbs_unit;

    localparam int W = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    zbs_unit_if #(.WIDTH(W)) bus ();

    zbs_unit #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] rs1,
                         input logic [W-1:0] rs2, input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.tag      = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.tag       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_y", bus.y, 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // bset latency: accepted in cycle N, visible in cycle N+2
        drive(2'b00, 64'd0, 64'd63, 5'd5);
        step();
        idle();
        chk("bset_n1_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("bset_valid", 64'(bus.out_valid), 64'd1);
        chk("bset_y", bus.y, 64'h8000_0000_0000_0000);
        chk("bset_tag", 64'(bus.out_tag), 64'd5);
`ifdef ZBS_ONEHOT_OUT_EN
        chk("bset_mask", bus.mask_out, 64'h8000_0000_0000_0000);
`endif
        step();
        chk("bset_drain", 64'(bus.out_valid), 64'd0);

        // back-to-back ops, one result per cycle
        drive(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd1);
        step();
        drive(2'b10, 64'd0, 64'h47, 5'd2);
        step();
        chk("bclr_y", bus.y, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("bclr_tag", 64'(bus.out_tag), 64'd1);
        drive(2'b11, 64'h10, 64'd4, 5'd3);
        step();
        chk("binv_y", bus.y, 64'h80);
        chk("binv_tag", 64'(bus.out_tag), 64'd2);
        drive(2'b11, 64'h10, 64'd5, 5'd4);
        step();
        idle();
        chk("bext1_y", bus.y, 64'd1);
        chk("bext1_tag", 64'(bus.out_tag), 64'd3);
        step();
        chk("bext0_valid", 64'(bus.out_valid), 64'd1);
        chk("bext0_y", bus.y, 64'd0);
        chk("bext0_tag", 64'(bus.out_tag), 64'd4);
        step();
        chk("stream_drain", 64'(bus.out_valid), 64'd0);

        // backpressure: two accepted, third stalls, order preserved
        bus.out_ready = 1'b0;
        drive(2'b00, 64'd0, 64'd1, 5'd1);
        step();
        drive(2'b00, 64'd0, 64'd2, 5'd2);
        chk("stall_rdy2", 64'(bus.in_ready), 64'd1);
        step();
        drive(2'b00, 64'd0, 64'd3, 5'd3);
        chk("stall_full_rdy", 64'(bus.in_ready), 64'd0);
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_tag_a", 64'(bus.out_tag), 64'd1);
        chk("stall_y_a", bus.y, 64'h2);
        step();
        chk("stall_hold_tag", 64'(bus.out_tag), 64'd1);
        chk("stall_hold_y", bus.y, 64'h2);
        chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("release_rdy", 64'(bus.in_ready), 64'd1);
        step();
        idle();
        chk("order_tag2", 64'(bus.out_tag), 64'd2);
        chk("order_y2", bus.y, 64'h4);
        step();
        chk("order_tag3", 64'(bus.out_tag), 64'd3);
        chk("order_y3", bus.y, 64'h8);
        step();
        chk("order_drain", 64'(bus.out_valid), 64'd0);

        // flush with both stages full and a new request handshaken
        bus.out_ready = 1'b0;
        drive(2'b00, 64'd0, 64'd10, 5'd10);
        step();
        drive(2'b00, 64'd0, 64'd11, 5'd11);
        step();
        drive(2'b00, 64'd0, 64'd12, 5'd12);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_in_rdy", 64'(bus.in_ready), 64'd1);
        step();
        bus.flush = 1'b0;
        idle();
        chk("flush_valid0", 64'(bus.out_valid), 64'd0);
        step();
        chk("flush_valid1", 64'(bus.out_valid), 64'd0);
        step();
        chk("flush_valid2", 64'(bus.out_valid), 64'd0);

        // reset mid-operation with the pipeline full
        bus.out_ready = 1'b0;
        drive(2'b00, 64'd0, 64'd20, 5'd20);
        step();
        drive(2'b00, 64'd0, 64'd21, 5'd21);
        step();
        idle();
        chk("prerst_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_y", bus.y, 64'd0);
        chk("midrst_tag", 64'(bus.out_tag), 64'd0);
        chk("midrst_rdy", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        drive(2'b00, 64'd0, 64'd1, 5'd7);
        step();
        idle();
        chk("postrst_n1_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("postrst_valid", 64'(bus.out_valid), 64'd1);
        chk("postrst_y", bus.y, 64'h2);
        chk("postrst_tag", 64'(bus.out_tag), 64'd7);
        step();
        chk("postrst_drain", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
